// File: rtl/univ_shift_reg_if.sv
// Bundles the operation controls, burst handshake and register outputs of
// univ_shift_reg. The slave modport is the register itself, the master modport
// is whatever drives it (a controller or a testbench).
interface univ_shift_reg_if #(
  parameter int BITS  = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic [2:0]       mode;
  logic             d_right;
  logic             d_left;
  logic [BITS-1:0]  load_val;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [BITS-1:0]  q;
  logic             so_msb;
  logic             so_lsb;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, d_right, d_left, load_val, start, count,
    input  q, so_msb, so_lsb, busy, done
  );

  modport slave (
    input  en, mode, d_right, d_left, load_val, start, count,
    output q, so_msb, so_lsb, busy, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left/right, rotate left/right,
// parallel load, arithmetic shift right and clear, selected per cycle by a
// 3-bit mode. A burst engine repeats one captured mode for 'count' enabled
// cycles and reports completion with a busy/done handshake.
module univ_shift_reg #(
  parameter int BITS  = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  univ_shift_reg_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_ROL  = 3'd3,
    OP_ROR  = 3'd4,
    OP_LOAD = 3'd5,
    OP_ASR  = 3'd6,
    OP_CLR  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state;
  op_e              mode_r;
  logic [CNT_W-1:0] cnt;
  logic [BITS-1:0]  q_r;
  logic             busy_r;
  logic             done_r;
  logic [BITS-1:0]  live_nxt;
  logic [BITS-1:0]  run_nxt;

  // Next register value for a given operation; pure data path, no state.
  function automatic logic [BITS-1:0] apply_op(
    input op_e             op,
    input logic [BITS-1:0] cur,
    input logic            dr,
    input logic            dl,
    input logic [BITS-1:0] lv
  );
    logic [BITS-1:0] res;
    res = cur;
    case (op)
      OP_HOLD: res = cur;
      OP_SHL:  res = {cur[BITS-2:0], dr};
      OP_SHR:  res = {dl, cur[BITS-1:1]};
      OP_ROL:  res = {cur[BITS-2:0], cur[BITS-1]};
      OP_ROR:  res = {cur[0], cur[BITS-1:1]};
      OP_LOAD: res = lv;
      OP_ASR:  res = {cur[BITS-1], cur[BITS-1:1]};
      OP_CLR:  res = '0;
      default: res = cur;
    endcase
    return res;
  endfunction

  // Direct operations use the live mode; burst steps use the captured one.
  assign live_nxt = apply_op(op_e'(bus.mode), q_r, bus.d_right, bus.d_left, bus.load_val);
  assign run_nxt  = apply_op(mode_r, q_r, bus.d_right, bus.d_left, bus.load_val);

  // Burst FSM and register update; busy/done are registered alongside q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: all state in clocked blocks uses non-blocking assignments so every
      // register samples the pre-edge values, regardless of statement order.
      state  <= IDLE;
      mode_r <= OP_HOLD;
      cnt    <= '0;
      q_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            // Start wins over en: capture the burst, leave q untouched this edge.
            mode_r <= op_e'(bus.mode);
            cnt    <= bus.count;
            if (bus.count == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state  <= RUN;
              busy_r <= 1'b1;
            end
          end else if (bus.en) begin
            q_r <= live_nxt;
          end
        end

        RUN: begin
          if (bus.en) begin
            q_r <= run_nxt;
            cnt <= cnt - CNT_W'(1);
            // Counter is at least 1 here, so the decrement never wraps.
            if (cnt == CNT_W'(1)) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q      = q_r;
  assign bus.so_msb = q_r[BITS-1];
  assign bus.so_lsb = q_r[0];
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (BITS=8, CNT_W=4): direct operations,
// asynchronous reset, bursts with pause, count=0, ignored inputs during a
// burst and reset in the middle of a burst.
module tb_univ_shift_reg;

  localparam int BITS  = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  univ_shift_reg_if #(.BITS(BITS), .CNT_W(CNT_W)) bus ();

  univ_shift_reg #(.BITS(BITS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle away from it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] lv);
    bus.en = 1'b1; bus.mode = m; bus.load_val = lv; bus.start = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.en = 1'b0; bus.mode = 3'd0; bus.d_right = 1'b0; bus.d_left = 1'b0;
    bus.load_val = 8'h00; bus.start = 1'b0; bus.count = 4'd0;

    step(); step();
    check("reset_q", bus.q, 8'h00);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    rst = 1'b1;
    step();

    // Direct operations
    op(3'd5, 8'hA5);                 check("load_a5", bus.q, 8'hA5);
    bus.d_right = 1'b1; op(3'd1, 8'h00); check("shl", bus.q, 8'h4B);
    bus.d_left = 1'b0;  op(3'd2, 8'h00); check("shr", bus.q, 8'h25);
    bus.en = 1'b0; bus.mode = 3'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("en0_hold", bus.q, 8'h25);
    end

    op(3'd5, 8'h81); op(3'd3, 8'h00);
    check("rol", bus.q, 8'h03);
    check("rol_so_lsb", bus.so_lsb, 1'b1);
    check("rol_so_msb", bus.so_msb, 1'b0);
    op(3'd5, 8'h81); op(3'd4, 8'h00);
    check("ror", bus.q, 8'hC0);
    check("ror_so_msb", bus.so_msb, 1'b1);
    check("ror_so_lsb", bus.so_lsb, 1'b0);
    op(3'd5, 8'h90);
    op(3'd6, 8'h00); check("asr1", bus.q, 8'hC8);
    op(3'd6, 8'h00); check("asr2", bus.q, 8'hE4);
    op(3'd7, 8'h00); check("clr", bus.q, 8'h00);

    // Asynchronous reset with no clock edge involved
    op(3'd5, 8'h5A); check("pre_async_rst", bus.q, 8'h5A);
    bus.mode = 3'd0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_q", bus.q, 8'h00);
    check("async_rst_busy", bus.busy, 1'b0);
    check("async_rst_done", bus.done, 1'b0);
    step();
    rst = 1'b1;
    step();
    check("post_rst_q", bus.q, 8'h00);

    // Burst: rotate left 3 times
    op(3'd5, 8'h01);
    bus.start = 1'b1; bus.mode = 3'd3; bus.count = 4'd3; bus.en = 1'b1;
    step();
    check("b1_start_q", bus.q, 8'h01);
    check("b1_start_busy", bus.busy, 1'b1);
    bus.start = 1'b0;
    step(); check("b1_q1", bus.q, 8'h02); check("b1_busy1", bus.busy, 1'b1);
    step(); check("b1_q2", bus.q, 8'h04); check("b1_busy2", bus.busy, 1'b1);
    step(); check("b1_q3", bus.q, 8'h08);
    check("b1_done", bus.done, 1'b1);
    check("b1_busy_end", bus.busy, 1'b0);
    step();                          // DONE cycle: en=1 mode=3 live, no effect
    check("b1_done_q_hold", bus.q, 8'h08);
    check("b1_done_clear", bus.done, 1'b0);

    // Burst with one paused cycle
    op(3'd5, 8'h01);
    bus.start = 1'b1; bus.mode = 3'd3; bus.count = 4'd3; bus.en = 1'b1;
    step(); check("b2_busy0", bus.busy, 1'b1);
    bus.start = 1'b0;
    step(); check("b2_q1", bus.q, 8'h02);
    bus.en = 1'b0;
    step(); check("b2_pause_q", bus.q, 8'h02); check("b2_pause_busy", bus.busy, 1'b1);
    check("b2_pause_done", bus.done, 1'b0);
    bus.en = 1'b1;
    step(); check("b2_q2", bus.q, 8'h04); check("b2_busy3", bus.busy, 1'b1);
    step(); check("b2_q3", bus.q, 8'h08); check("b2_done", bus.done, 1'b1);
    bus.en = 1'b0;
    step(); check("b2_done_clear", bus.done, 1'b0);

    // count=0: immediate done, no busy, q unchanged
    bus.start = 1'b1; bus.mode = 3'd1; bus.count = 4'd0; bus.en = 1'b1;
    step();
    check("c0_done", bus.done, 1'b1);
    check("c0_busy", bus.busy, 1'b0);
    check("c0_q", bus.q, 8'h08);
    bus.start = 1'b0; bus.en = 1'b0;
    step();
    check("c0_done_clear", bus.done, 1'b0);
    check("c0_q_after", bus.q, 8'h08);

    // Start and mode changes during RUN are ignored; start in DONE ignored
    op(3'd5, 8'h01);
    bus.start = 1'b1; bus.mode = 3'd3; bus.count = 4'd2; bus.en = 1'b1;
    step();
    bus.start = 1'b1; bus.mode = 3'd5; bus.load_val = 8'hFF;
    step(); check("ign_q1", bus.q, 8'h02); check("ign_busy", bus.busy, 1'b1);
    bus.start = 1'b0; bus.mode = 3'd2;
    step(); check("ign_q2", bus.q, 8'h04); check("ign_done", bus.done, 1'b1);
    bus.start = 1'b1; bus.count = 4'd3;
    step();
    check("done_start_busy", bus.busy, 1'b0);
    check("done_start_q", bus.q, 8'h04);
    bus.start = 1'b0; bus.en = 1'b0;
    step();
    check("done_start_idle", bus.busy, 1'b0);

    // Start with en=1 and mode1 on the same IDLE edge: no shift that edge
    bus.start = 1'b1; bus.mode = 3'd1; bus.count = 4'd1; bus.en = 1'b1; bus.d_right = 1'b1;
    step(); check("se_q", bus.q, 8'h04); check("se_busy", bus.busy, 1'b1);
    bus.start = 1'b0;
    step(); check("se_q1", bus.q, 8'h09); check("se_done", bus.done, 1'b1);
    bus.en = 1'b0;
    step();

    // Reset after 2 of 5 steps
    op(3'd5, 8'h01);
    bus.start = 1'b1; bus.mode = 3'd3; bus.count = 4'd5; bus.en = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step();
    check("rb_q2", bus.q, 8'h04);
    #2 rst = 1'b0;
    #1;
    check("rb_q", bus.q, 8'h00);
    check("rb_busy", bus.busy, 1'b0);
    check("rb_done", bus.done, 1'b0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rb_no_done", bus.done, 1'b0);
    end
    check("rb_no_busy", bus.busy, 1'b0);
    op(3'd5, 8'h01);
    bus.start = 1'b1; bus.mode = 3'd3; bus.count = 4'd1; bus.en = 1'b1;
    step(); check("rb_new_busy", bus.busy, 1'b1);
    bus.start = 1'b0;
    step(); check("rb_new_q", bus.q, 8'h02); check("rb_new_done", bus.done, 1'b1);
    step(); check("rb_new_done_clear", bus.done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the basic serial-in shift register.
- Supports bidirectional shift, rotate, arithmetic shift, parallel load and clear, selected per cycle by a mode code.
- Adds a burst engine: a single start request performs N consecutive operations, with a busy/done handshake.
- Drives LED chaser and pattern displays and serial-link staging in the examples tree.

Parameters:
- BITS, 8: register width; legal range 2 and up.
- CNT_W, 4: width of the burst count port; must satisfy 2**CNT_W-1 >= required burst length.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  operation enable; gates direct operations and burst steps.
- mode  input  3  operation select (encoding below).
- d_right  input  1  serial input entering bit 0 on left shift.
- d_left  input  1  serial input entering bit BITS-1 on right shift.
- load_val  input  BITS  parallel load value.
- start  input  1  burst request; sampled only in IDLE.
- count  input  CNT_W  number of burst steps.
- q  output  BITS  register contents.
- so_msb  output  1  q[BITS-1], combinational from q.
- so_lsb  output  1  q[0], combinational from q.
- busy  output  1  high while the burst is in RUN.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (rst=0, asynchronous): q=0, state=IDLE, busy=0, done=0, captured mode=0, step counter=0. Reset dominates everything, including a burst in progress.
- Mode encoding, applied to q at the clock edge:
  - 0: hold.
  - 1: shift left, q <= {q[BITS-2:0], d_right}.
  - 2: shift right, q <= {d_left, q[BITS-1:1]}.
  - 3: rotate left.
  - 4: rotate right.
  - 5: parallel load, q <= load_val.
  - 6: arithmetic shift right; MSB is replicated.
  - 7: clear, q <= 0.
- IDLE, direct mode:
  - en=1 and start=0: apply the live mode at the edge. Latency is 1 clock.
  - en=0: hold.
  - start=1: start takes priority over en. Capture mode to mode_r and count to the step counter; no operation on q this edge.
  - If count=0: go to DONE. Otherwise go to RUN.
- RUN:
  - busy=1.
  - Each edge with en=1: apply mode_r, decrement the counter.
  - Each edge with en=0: pause; q and counter hold, busy stays 1.
  - When the counter decrements 1 -> 0: go to DONE on that same edge.
  - The live mode, start and count inputs are ignored.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start during DONE is ignored.
  - en in DONE has no effect on q.
- Burst timing: start sampled at edge k with en held high gives shifts at edges k+1..k+N, and done is high in the cycle after edge k+N.
- Mode 5 in a burst reloads load_val every step; the final q equals load_val sampled at the last step.
- Outputs q, busy and done are registered.
- Width rules: no arithmetic on q. The counter is CNT_W bits and never wraps, because a decrement only occurs from a value of at least 1.

Test Plan:
- Reset: drive rst=0 mid-operation with q=0x5A -> q=0x00, busy=0, done=0 immediately, without waiting for a clock edge; release -> IDLE.
- Direct shifts, BITS=8:
  - mode5, load_val=0xA5 -> q=0xA5.
  - mode1, d_right=1 -> 0x4B.
  - mode2, d_left=0 -> 0x25.
  - en=0 for 3 cycles -> q holds 0x25.
- Rotate and arithmetic shifts:
  - q=0x81, mode3 -> 0x03.
  - reload 0x81, mode4 -> 0xC0.
  - q=0x90, mode6 twice -> 0xC8, then 0xE4.
  - mode7 -> 0x00.
- Burst with pause:
  - q=0x01, start with mode3, count=3, en=1 -> busy 3 cycles, q=0x02/0x04/0x08, then a single done pulse.
  - Repeat with en=0 for one cycle mid-run -> busy 4 cycles, same final q=0x08.
- Burst edge cases:
  - count=0 -> done pulses the cycle after start, busy never rises, q unchanged.
  - start pulsed during RUN, and mode changed during RUN -> ignored; result follows the captured mode.
  - start and en=1 with mode1 on the same IDLE edge -> no shift that edge.
- Reset mid-burst: assert rst after 2 of 5 steps -> q=0, busy=0, done never pulses; a new start after release works normally.
